// File: rtl/minimac2_rxdma_if.sv
// WISHBONE master bus bundle used by minimac2_rxdma; the master modport belongs to the DMA,
// the slave modport to the memory side.
interface minimac2_rxdma_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o, wbm_we_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o, wbm_we_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/minimac2_rxdma.sv
// RX DMA: copies a received frame word-by-word from a MAC RX slot to system memory over WISHBONE.
// Define MINIMAC2_RXDMA_CRC_EN to add a CRC-32 residue check over the copied bytes.
module minimac2_rxdma #(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [14:0]      csr_a,
    input  logic             csr_we,
    input  logic [31:0]      csr_di,
    output logic [31:0]      csr_do,
    output logic             irq,
    minimac2_rxdma_if.master wbm
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d;
    logic [10:0] len_q, len_d;
    logic [31:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [9:0]  remain_q, remain_d;
    logic [31:0] word_q, word_d;
    logic        gap_q, gap_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        irq_en_q, irq_en_d, crc_ok_q, crc_ok_d;
    logic [31:0] csr_do_q, csr_do_d;

    logic        csr_sel, csr_wr, start, stb, bus_ack, bus_err;
    logic [2:0]  reg_idx;
    logic [10:0] len_sum;
    logic [9:0]  word_cnt;
    logic        unused_bits;

`ifdef MINIMAC2_RXDMA_CRC_EN
    logic [31:0] crc_q, crc_d;
    logic [2:0]  crc_nbytes;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w,
                                             input logic [2:0] n);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 4; k++)
            if (3'(k) < n) r = crc_byte(r, w[31 - 8*k -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        return r;
    endfunction
`endif

    always_comb begin
        csr_sel  = (csr_a[13:10] == csr_addr);
        csr_wr   = csr_sel && csr_we;
        reg_idx  = csr_a[2:0];
        len_sum  = len_q + 11'd3;
        word_cnt = {1'b0, len_sum[10:2]};
        start    = csr_wr && (reg_idx == 3'd0) && csr_di[0] && (state_q == S_IDLE);
        // One idle cycle after every ack keeps back-to-back strobes apart.
        stb      = ((state_q == S_READ) || (state_q == S_WRITE)) && !gap_q;
        bus_err  = stb && wbm.wbm_err_i;
        bus_ack  = stb && wbm.wbm_ack_i && !wbm.wbm_err_i;

        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        remain_d  = remain_q;
        word_d    = word_q;
        gap_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        irq_en_d  = irq_en_q;
        crc_ok_d  = crc_ok_q;
`ifdef MINIMAC2_RXDMA_CRC_EN
        crc_d      = crc_q;
        crc_nbytes = ((remain_q == 10'd1) && (len_q[1:0] != 2'd0)) ? {1'b0, len_q[1:0]} : 3'd4;
`endif

        if (csr_wr && !busy_q) begin
            case (reg_idx)
                3'd1:    src_d = {csr_di[31:2], 2'b00};
                3'd2:    dst_d = {csr_di[31:2], 2'b00};
                3'd3:    len_d = csr_di[10:0];
                default: ;
            endcase
        end

        if (csr_wr && (reg_idx == 3'd0)) begin
            irq_en_d = csr_di[1];
            if (csr_di[2]) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
        end

        if (start) begin
            busy_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            crc_ok_d  = 1'b0;
            remain_d  = word_cnt;
            src_ptr_d = src_q;
            dst_ptr_d = dst_q;
            state_d   = (word_cnt == 10'd0) ? S_FINISH : S_READ;
`ifdef MINIMAC2_RXDMA_CRC_EN
            crc_d     = 32'hFFFF_FFFF;
`endif
        end

        // err outranks ack; pointers and remain stay where the failing cycle left them.
        if (bus_err) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_READ: begin
                    if (bus_ack) begin
                        word_d  = wbm.wbm_dat_i;
                        gap_d   = 1'b1;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus_ack) begin
                        src_ptr_d = src_ptr_q + 32'd4;
                        dst_ptr_d = dst_ptr_q + 32'd4;
                        remain_d  = remain_q - 10'd1;
                        gap_d     = 1'b1;
                        state_d   = (remain_q == 10'd1) ? S_FINISH : S_READ;
`ifdef MINIMAC2_RXDMA_CRC_EN
                        crc_d     = crc_word(crc_q, word_q, crc_nbytes);
`endif
                    end
                end
                S_FINISH: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef MINIMAC2_RXDMA_CRC_EN
                    // The reflected register holds the bit-reversed form of the magic residue.
                    crc_ok_d = (bit_rev(crc_q) == 32'hC704_DD7B);
`endif
                end
                default: ;
            endcase
        end

        csr_do_d = 32'd0;
        if (csr_sel) begin
            case (reg_idx)
                3'd0:    csr_do_d = {27'd0, crc_ok_q, err_q, done_q, irq_en_q, busy_q};
                3'd1:    csr_do_d = src_q;
                3'd2:    csr_do_d = dst_q;
                3'd3:    csr_do_d = {21'd0, len_q};
                3'd4:    csr_do_d = {22'd0, remain_q};
                default: csr_do_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= 11'd0;
            src_ptr_q <= 32'd0;
            dst_ptr_q <= 32'd0;
            remain_q  <= 10'd0;
            gap_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            crc_ok_q  <= 1'b0;
            csr_do_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            remain_q  <= remain_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            crc_ok_q  <= crc_ok_d;
            csr_do_q  <= csr_do_d;
        end
    end

    // Datapath holding registers; only ever observed through state-gated outputs.
    always_ff @(posedge sys_clk) begin
        word_q <= word_d;
`ifdef MINIMAC2_RXDMA_CRC_EN
        crc_q  <= crc_d;
`endif
    end

    assign csr_do         = csr_do_q;
    assign irq            = done_q && irq_en_q;
    assign wbm.wbm_stb_o  = stb;
    assign wbm.wbm_cyc_o  = stb;
    assign wbm.wbm_we_o   = (state_q == S_WRITE);
    assign wbm.wbm_sel_o  = 4'hF;
    assign wbm.wbm_adr_o  = (state_q == S_READ)  ? src_ptr_q :
                            (state_q == S_WRITE) ? dst_ptr_q : 32'd0;
    assign wbm.wbm_dat_o  = (state_q == S_WRITE) ? word_q : 32'd0;
    assign unused_bits    = ^{csr_a[14], csr_a[9:3], len_sum[1:0]};

endmodule

// File: tb/tb_minimac2_rxdma.sv
// Directed bench for minimac2_rxdma: table of copy transfers plus hand sequences for
// delayed ack, bus error, reset mid-transfer and the optional CRC check.
module tb_minimac2_rxdma;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [14:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;

    minimac2_rxdma_if bus();

    minimac2_rxdma #(.csr_addr(4'h0)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq     (irq),
        .wbm     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [10:0] len;
        int          words;
        logic [31:0] last_wr;
    } vec_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          ack_delay = 0;
    int          err_rd_idx = -1;
    int          wait_cnt = 0;
    int          viol = 0;
    int          stb_cycles = 0;
    logic        mon_en = 1'b1;
    logic        p_stb = 1'b0, p_ack = 1'b0, p_err = 1'b0, p_we = 1'b0;
    logic [31:0] p_adr = 32'd0, p_dat = 32'd0;
    logic [31:0] src_mem [0:255];
    logic [31:0] rd_adr_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    // Memory slave: acks after ack_delay wait cycles, or errors the chosen read.
    always @(posedge sys_clk) begin
        if (sys_rst || bus.wbm_stb_o !== 1'b1 || bus.wbm_ack_i || bus.wbm_err_i) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            wait_cnt      <= 0;
        end else if (wait_cnt < ack_delay) begin
            wait_cnt <= wait_cnt + 1;
        end else if (!bus.wbm_we_o && rd_adr_q.size() == err_rd_idx) begin
            bus.wbm_err_i <= 1'b1;
        end else begin
            bus.wbm_ack_i <= 1'b1;
            if (!bus.wbm_we_o) begin
                bus.wbm_dat_i <= src_mem[8'((bus.wbm_adr_o - 32'h0000_1000) >> 2)];
                rd_adr_q.push_back(bus.wbm_adr_o);
            end else begin
                wr_adr_q.push_back(bus.wbm_adr_o);
                wr_dat_q.push_back(bus.wbm_dat_o);
            end
        end
    end

    // Protocol monitor: cyc==stb, strobe held with stable adr/we/dat until ack/err, gap after ack/err.
    always @(negedge sys_clk) begin
        if (bus.wbm_stb_o === 1'b1) stb_cycles <= stb_cycles + 1;
        if (mon_en && !sys_rst) begin
            if ((bus.wbm_cyc_o !== bus.wbm_stb_o) ||
                (p_stb && !p_ack && !p_err &&
                 (bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== p_adr || bus.wbm_we_o !== p_we ||
                  (p_we && bus.wbm_dat_o !== p_dat))) ||
                (p_stb && (p_ack || p_err) && bus.wbm_stb_o === 1'b1))
                viol <= viol + 1;
        end
        p_stb <= (bus.wbm_stb_o === 1'b1);
        p_ack <= (bus.wbm_ack_i === 1'b1);
        p_err <= (bus.wbm_err_i === 1'b1);
        p_we  <= bus.wbm_we_o;
        p_adr <= bus.wbm_adr_o;
        p_dat <= bus.wbm_dat_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [14:0] mk_a(input logic [3:0] bank, input logic [2:0] r);
        return {1'b0, bank, 7'd0, r};
    endfunction

    task automatic csr_write(input logic [2:0] r, input logic [31:0] v);
        @(negedge sys_clk);
        csr_a  = mk_a(4'h0, r);
        csr_di = v;
        csr_we = 1'b1;
        @(posedge sys_clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] bank, input logic [2:0] r, output logic [31:0] v);
        @(negedge sys_clk);
        csr_a  = mk_a(bank, r);
        csr_we = 1'b0;
        @(posedge sys_clk);
        #1;
        v = csr_do;
    endtask

    task automatic clear_logs();
        rd_adr_q.delete();
        wr_adr_q.delete();
        wr_dat_q.delete();
    endtask

    task automatic program_xfer(input logic [31:0] s, input logic [31:0] d, input logic [10:0] l,
                                input logic [31:0] ctrl);
        clear_logs();
        csr_write(3'd1, s);
        csr_write(3'd2, d);
        csr_write(3'd3, {21'd0, l});
        csr_write(3'd0, ctrl);
    endtask

    task automatic wait_irq(output int waited);
        waited = 0;
        while (irq !== 1'b1 && waited < 2000) begin
            @(posedge sys_clk);
            #1;
            waited++;
        end
    endtask

    function automatic logic [31:0] ref_crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    initial begin
        vec_t        vecs [7];
        logic [31:0] v;
        logic [31:0] crc;
        logic [7:0]  fb [0:63];
        logic        exp_crc_ok;
        int          waited, bad, base, s0;

        vecs[0] = '{32'h0000_1000, 32'h4000_0000, 11'd8,  2, 32'h4000_0004};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 11'd5,  2, 32'h0000_2004};
        vecs[2] = '{32'h0000_1010, 32'h0000_3000, 11'd12, 3, 32'h0000_3008};
        vecs[3] = '{32'h0000_1004, 32'h0000_5000, 11'd1,  1, 32'h0000_5000};
        vecs[4] = '{32'h0000_1000, 32'hFFFF_FFFC, 11'd8,  2, 32'h0000_0000};
        vecs[5] = '{32'h0000_1000, 32'h0000_6000, 11'd0,  0, 32'h0000_0000};
        vecs[6] = '{32'h0000_1020, 32'h0000_7000, 11'd4,  1, 32'h0000_7000};

`ifdef MINIMAC2_RXDMA_CRC_EN
        exp_crc_ok = 1'b1;
`else
        exp_crc_ok = 1'b0;
`endif

        for (int i = 0; i < 256; i++) src_mem[i] = (i * 32'h0103_0507) ^ 32'h5A00_C3A5;

        sys_rst = 1'b1;
        csr_a   = '0;
        csr_we  = 1'b0;
        csr_di  = '0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Reset state
        check("rst_irq", irq, 0);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("sel_const", bus.wbm_sel_o, 4'hF);
        for (int r = 0; r < 5; r++) begin
            csr_read(4'h0, 3'(r), v);
            check($sformatf("rst_reg%0d", r), v, 0);
        end

        // Address alignment and bank select
        csr_write(3'd1, 32'h0000_1003);
        csr_read(4'h0, 3'd1, v);
        check("src_low_bits", v, 32'h0000_1000);
        csr_read(4'h3, 3'd1, v);
        check("bank_unselected", v, 0);

        // Table of transfers
        for (int i = 0; i < 7; i++) begin
            program_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, 32'd3);
            wait_irq(waited);
            check($sformatf("v%0d_timeout", i), (waited < 2000), 1);
            check($sformatf("v%0d_rd_cnt", i), rd_adr_q.size(), vecs[i].words);
            check($sformatf("v%0d_wr_cnt", i), wr_adr_q.size(), vecs[i].words);
            bad = 0;
            base = int'((vecs[i].src - 32'h0000_1000) >> 2);
            if (rd_adr_q.size() != vecs[i].words || wr_adr_q.size() != vecs[i].words) bad = 1;
            else
                for (int k = 0; k < vecs[i].words; k++) begin
                    if (rd_adr_q[k] !== vecs[i].src + 32'(4 * k)) bad++;
                    if (wr_adr_q[k] !== vecs[i].dst + 32'(4 * k)) bad++;
                    if (wr_dat_q[k] !== src_mem[base + k]) bad++;
                end
            check($sformatf("v%0d_adr_data", i), bad, 0);
            if (vecs[i].words > 0)
                check($sformatf("v%0d_last_wr", i), wr_adr_q[wr_adr_q.size() - 1], vecs[i].last_wr);
            csr_read(4'h0, 3'd0, v);
            check($sformatf("v%0d_ctrl", i), v, 32'h6);
            csr_read(4'h0, 3'd4, v);
            check($sformatf("v%0d_remain", i), v, 0);
            csr_write(3'd0, 32'd4);
            check($sformatf("v%0d_irq_clr", i), irq, 0);
            csr_read(4'h0, 3'd0, v);
            check($sformatf("v%0d_ctrl_clr", i), v, 0);
        end

        // Zero length: done exactly one cycle after the start write
        program_xfer(32'h0000_1000, 32'h0000_6000, 11'd0, 32'd3);
        @(posedge sys_clk);
        #1;
        check("len0_done_next", irq, 1);
        repeat (3) @(posedge sys_clk);
        check("len0_no_bus", rd_adr_q.size() + wr_adr_q.size(), 0);

        // Start together with done-clear: start wins
        csr_write(3'd3, 32'd8);
        csr_write(3'd0, 32'd7);
        csr_read(4'h0, 3'd0, v);
        check("start_wins", v, 32'h3);
        wait_irq(waited);
        check("start_wins_done", (waited < 2000), 1);
        csr_write(3'd0, 32'd4);

        // Delayed ack, write ignored while busy, error on the 2nd read
        ack_delay  = 3;
        err_rd_idx = 1;
        program_xfer(32'h0000_1000, 32'h0000_9000, 11'd16, 32'd3);
        csr_write(3'd1, 32'hDEAD_0000);
        waited = 0;
        while (bus.wbm_err_i !== 1'b1 && waited < 200) begin
            @(posedge sys_clk);
            #1;
            waited++;
        end
        check("err_seen", (waited < 200), 1);
        @(posedge sys_clk);
        #1;
        check("err_cyc_drop", bus.wbm_cyc_o, 0);
        check("err_irq", irq, 1);
        csr_read(4'h0, 3'd4, v);
        check("err_remain", v, 3);
        csr_read(4'h0, 3'd0, v);
        check("err_ctrl", v, 32'hE);
        csr_read(4'h0, 3'd1, v);
        check("busy_src_locked", v, 32'h0000_1000);
        repeat (10) @(posedge sys_clk);
        check("err_wr_cnt", wr_adr_q.size(), 1);
        check("err_rd_cnt", rd_adr_q.size(), 1);
        ack_delay  = 0;
        err_rd_idx = -1;
        csr_write(3'd0, 32'd4);
        check("bus_protocol", viol, 0);

        // Reset in the middle of a write cycle
        ack_delay = 5;
        program_xfer(32'h0000_1000, 32'h0000_A000, 11'd16, 32'd3);
        waited = 0;
        while (!(bus.wbm_stb_o === 1'b1 && bus.wbm_we_o === 1'b1) && waited < 200) begin
            @(posedge sys_clk);
            #1;
            waited++;
        end
        check("rst_mid_write_reached", (waited < 200), 1);
        mon_en = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("rst_mid_cyc", bus.wbm_cyc_o, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        s0 = stb_cycles;
        for (int r = 0; r < 5; r++) begin
            csr_read(4'h0, 3'(r), v);
            check($sformatf("rst_mid_reg%0d", r), v, 0);
        end
        repeat (20) @(posedge sys_clk);
        check("rst_mid_no_bus", stb_cycles - s0, 0);
        mon_en    = 1'b1;
        ack_delay = 0;

        // 64-byte frame with valid FCS, then with one flipped data bit
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            fb[i] = 8'(i * 7 + 3);
            crc = ref_crc_byte(crc, fb[i]);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) fb[60 + k] = crc[8*k +: 8];
        for (int w = 0; w < 16; w++)
            src_mem[128 + w] = {fb[4*w], fb[4*w + 1], fb[4*w + 2], fb[4*w + 3]};

        program_xfer(32'h0000_1200, 32'h0000_B000, 11'd64, 32'd3);
        wait_irq(waited);
        check("crc_good_done", (waited < 2000), 1);
        csr_read(4'h0, 3'd0, v);
        check("crc_good_ok", v[4], exp_crc_ok);
        csr_write(3'd0, 32'd4);

        src_mem[130] = src_mem[130] ^ 32'h0001_0000;
        program_xfer(32'h0000_1200, 32'h0000_B000, 11'd64, 32'd3);
        wait_irq(waited);
        check("crc_bad_done", (waited < 2000), 1);
        csr_read(4'h0, 3'd0, v);
        check("crc_bad_ok", v[4], 0);
        csr_write(3'd0, 32'd4);

        check("bus_protocol_final", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
